flash_spi_reader: RTL and testbench



---
 rtl/flash_spi_reader.sv | 131 +++++++++++++
 tb/tb_flash_spi_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_spi_reader.sv
// flash_spi_reader: single-bit SPI READ (0x03) master that fetches a block of flash bytes
// and streams them out one byte per rd_valid strobe.
module flash_spi_reader #(
    parameter int HALF_DIV = 1,
    parameter int LEN_W    = 8
) (
    input  logic             clk_25m,
    input  logic             sys_rstn,
    input  logic             start_i,
    input  logic [23:0]      addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    output logic             spi_cclk_o,
    output logic             spi_cs_n_o,
    output logic             spi_mosi_o,
    output logic             spi_mosi_oe_n_o,
    input  logic             spi_miso_i,
    output logic             spi_wp_n_o,
    output logic             spi_hold_n_o
);
    localparam int DW = $clog2(2 * HALF_DIV);
    localparam logic [DW-1:0] HALF_M1 = DW'(HALF_DIV - 1);
    localparam logic [DW-1:0] GAP_M1 = DW'(2 * HALF_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE = DW'(1);
    localparam logic [LEN_W:0] CMD_BYTES = (LEN_W+1)'(4);
    localparam logic [LEN_W:0] BYTE_ONE = (LEN_W+1)'(1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [31:0]       sh_q, sh_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W:0]    byte_q, byte_d;
    logic [2:0]        bit_q, bit_d;
    logic              miso_q, miso_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              last_half, data_ph, active;

    assign last_half = div_q == '0;
    // byte_q counts the four command bytes plus the data bytes still to go
    assign data_ph = byte_q <= {1'b0, len_q};
    assign active = state_q inside {SETUP, SHIFT_HI, SHIFT_LO, HOLD};

    always_ff @(posedge clk_25m or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= IDLE;
            div_q      <= '0;
            sh_q       <= '0;
            len_q      <= '0;
            byte_q     <= '0;
            bit_q      <= '0;
            miso_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            sh_q       <= sh_d;
            len_q      <= len_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
            miso_q     <= miso_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sh_d       = sh_q;
        len_d      = len_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        miso_d     = miso_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = (len_i != '0) ? SETUP : GAP;
                div_d   = (len_i != '0) ? HALF_M1 : '0;
                sh_d    = {8'h03, addr_i};
                len_d   = len_i;
                byte_d  = {1'b0, len_i} + CMD_BYTES;
                bit_d   = '0;
            end
            SETUP, SHIFT_LO: if (last_half) begin
                state_d = SHIFT_HI;
                div_d   = HALF_M1;
                miso_d  = spi_miso_i;
            end else div_d = div_q - DIV_ONE;
            SHIFT_HI: begin
                // the byte's last sample was taken on the edge that opened this half
                if (div_q == HALF_M1 && data_ph && bit_q == 3'd7) begin
                    rd_data_d  = {sh_q[6:0], miso_q};
                    rd_valid_d = 1'b1;
                end
                if (last_half) begin
                    state_d = (bit_q == 3'd7 && byte_q == BYTE_ONE) ? HOLD : SHIFT_LO;
                    div_d   = HALF_M1;
                    sh_d    = {sh_q[30:0], miso_q};
                    bit_d   = bit_q + 3'd1;
                    byte_d  = (bit_q == 3'd7) ? byte_q - BYTE_ONE : byte_q;
                end else div_d = div_q - DIV_ONE;
            end
            HOLD: if (last_half) begin
                state_d = GAP;
                div_d   = GAP_M1;
            end else div_d = div_q - DIV_ONE;
            GAP: if (last_half) state_d = IDLE;
                 else div_d = div_q - DIV_ONE;
            default: state_d = IDLE;
        endcase
    end

    assign spi_cs_n_o      = !active;
    assign spi_cclk_o      = state_q == SHIFT_HI;
    assign spi_mosi_oe_n_o = !(active && !data_ph);
    assign spi_mosi_o      = !spi_mosi_oe_n_o && sh_q[31];
    assign busy_o          = state_q != IDLE;
    assign done_o          = state_q == GAP && last_half;
    assign rd_data_o       = rd_data_q;
    assign rd_valid_o      = rd_valid_q;
    assign spi_wp_n_o      = 1'b1;
    assign spi_hold_n_o    = 1'b1;
endmodule

// File: tb/tb_flash_spi_reader.sv
// tb_flash_spi_reader: randomized frames on HALF_DIV=1 and HALF_DIV=3 readers against a
// flash model and frame timing computed from the transfer rules.
module tb_flash_spi_reader;
    logic clk_25m = 1'b0;
    logic sys_rstn = 1'b0;
    logic start = 1'b0, sel = 1'b0;
    logic [23:0] addr = '0;
    logic [7:0] len = '0;
    logic miso;
    logic [1:0] busy_v, done_v, rdv_v, cclk_v, csn_v, mosi_v, oe_v, wp_v, hold_v;
    logic [7:0] rdd0, rdd1;
    logic busy, done, rdv, cclk, csn, mosi, oe_n;
    logic [7:0] rdd;
    logic [7:0] fdata [16];
    int cyc = 0, n_chk = 0, n_fail = 0;
    int rises = 0, frames, cs_fall_cyc, cs_low_cnt, done_cnt, done_cyc, busy_cnt;
    int oe_err, idle_err, cclk_hi, run, hi_min, hi_max, lo_min, lo_max;
    logic [31:0] cmd_word;
    logic prev_csn = 1'b1, prev_cclk = 1'b0;
    logic [7:0] rx_q [$];
    int rx_t [$];

    always #20 clk_25m = ~clk_25m;
    always @(posedge clk_25m) cyc <= cyc + 1;

    flash_spi_reader #(.HALF_DIV(1), .LEN_W(8)) u_div1 (
        .clk_25m(clk_25m), .sys_rstn(sys_rstn), .start_i(start && !sel), .addr_i(addr), .len_i(len),
        .busy_o(busy_v[0]), .done_o(done_v[0]), .rd_data_o(rdd0), .rd_valid_o(rdv_v[0]),
        .spi_cclk_o(cclk_v[0]), .spi_cs_n_o(csn_v[0]), .spi_mosi_o(mosi_v[0]), .spi_mosi_oe_n_o(oe_v[0]),
        .spi_miso_i(miso), .spi_wp_n_o(wp_v[0]), .spi_hold_n_o(hold_v[0]));

    flash_spi_reader #(.HALF_DIV(3), .LEN_W(8)) u_div3 (
        .clk_25m(clk_25m), .sys_rstn(sys_rstn), .start_i(start && sel), .addr_i(addr), .len_i(len),
        .busy_o(busy_v[1]), .done_o(done_v[1]), .rd_data_o(rdd1), .rd_valid_o(rdv_v[1]),
        .spi_cclk_o(cclk_v[1]), .spi_cs_n_o(csn_v[1]), .spi_mosi_o(mosi_v[1]), .spi_mosi_oe_n_o(oe_v[1]),
        .spi_miso_i(miso), .spi_wp_n_o(wp_v[1]), .spi_hold_n_o(hold_v[1]));

    // only one reader is ever active, so the idle one's outputs merge away
    assign busy = |busy_v;
    assign done = |done_v;
    assign rdv = |rdv_v;
    assign rdd = rdv_v[1] ? rdd1 : rdd0;
    assign cclk = |cclk_v;
    assign csn = &csn_v;
    assign mosi = |mosi_v;
    assign oe_n = &oe_v;

    // flash drives data bit i during the low half after the (32+i)th rising SCLK edge
    always_comb begin
        miso = 1'b0;
        if (rises >= 32 && rises < 160) miso = fdata[(rises - 32) >> 3][7 - ((rises - 32) & 7)];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rec(input logic c, input int r);
        if (c) begin
            hi_min = r < hi_min ? r : hi_min;
            hi_max = r > hi_max ? r : hi_max;
        end else begin
            lo_min = r < lo_min ? r : lo_min;
            lo_max = r > lo_max ? r : lo_max;
        end
    endtask

    always @(negedge clk_25m) begin
        if (!csn && prev_csn) begin
            frames++;
            cs_fall_cyc = cyc;
            rises = 0;
        end
        if (!csn) cs_low_cnt++;
        if (busy) busy_cnt++;
        if (cclk) cclk_hi++;
        if (csn && cclk) idle_err++;
        if (!csn && cclk && !prev_cclk) begin
            if (rises < 32) cmd_word = {cmd_word[30:0], mosi};
            rises++;
        end
        if (!csn && (oe_n !== (rises > 32 || (rises == 32 && !cclk)) || (oe_n && mosi))) oe_err++;
        if (!csn && !prev_csn && cclk == prev_cclk) run++;
        else begin
            if (!prev_csn) rec(prev_cclk, run);
            run = 1;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rdv) begin
            rx_q.push_back(rdd);
            rx_t.push_back(cyc);
        end
        prev_csn = csn;
        prev_cclk = cclk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_25m);
        #1;
    endtask

    task automatic clear_mon();
        frames = 0; cs_low_cnt = 0; done_cnt = 0; busy_cnt = 0; oe_err = 0; idle_err = 0;
        cclk_hi = 0; rises = 0; cs_fall_cyc = -1; done_cyc = -1;
        hi_min = 1000000; hi_max = 0; lo_min = 1000000; lo_max = 0;
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic launch(input logic s, input logic [23:0] a, input int l, output int t0);
        clear_mon();
        sel = s; addr = a; len = 8'(l); start = 1'b1;
        t0 = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && done_cnt == 0; i++) tick(1);
        check("done_seen", done_cnt > 0, 1);
        tick(2);
    endtask

    task automatic check_frame(input int h, input logic [23:0] a, input int l, input int t0);
        int n;
        n = 32 + 8 * l;
        check("cmd_addr", cmd_word, {8'h03, a});
        check("sclk_rises", rises, n);
        check("cs_fall", cs_fall_cyc, t0 + 1);
        check("cs_low", cs_low_cnt, (2 * n + 1) * h);
        check("done_cyc", done_cyc, t0 + (2 * n + 3) * h);
        check("done_cnt", done_cnt, 1);
        check("busy_cnt", busy_cnt, (2 * n + 3) * h);
        check("oe_mosi", oe_err, 0);
        check("sclk_idle", idle_err, 0);
        check("hi_min", hi_min, h);
        check("hi_max", hi_max, h);
        check("lo_min", lo_min, h);
        check("lo_max", lo_max, h);
        check("rx_count", rx_q.size(), l);
        for (int k = 0; k < l && k < rx_q.size(); k++) begin
            check("rx_data", rx_q[k], fdata[k]);
            if (h == 1) check("rx_time", rx_t[k], t0 + 81 + 16 * k);
        end
        check("busy_end", busy, 0);
    endtask

    initial begin
        #(60000 * 40);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, d1, l;
        logic s;
        logic [23:0] a;
        for (int i = 0; i < 16; i++) fdata[i] = 8'($urandom);
        tick(4);
        check("rst_cs_n", csn, 1);
        check("rst_cclk", cclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_oe_n", oe_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdv", rdv, 0);
        check("rst_rdd", {rdd0, rdd1}, 0);
        check("wp_hold", {wp_v, hold_v}, 4'hf);
        sys_rstn = 1'b1;
        tick(2);

        fdata[0] = 8'hA5;
        launch(0, 24'h012345, 1, t0);
        wait_done();
        check_frame(1, 24'h012345, 1, t0);

        fdata[0] = 8'h11; fdata[1] = 8'h22; fdata[2] = 8'h33; fdata[3] = 8'h44;
        a = 24'($urandom);
        launch(0, a, 4, t0);
        wait_done();
        check_frame(1, a, 4, t0);

        fdata[0] = 8'($urandom);
        launch(1, 24'hABCDEF, 1, t0);
        wait_done();
        check_frame(3, 24'hABCDEF, 1, t0);

        for (int k = 0; k < 2; k++) begin
            launch(k[0], 24'($urandom), 0, t0);
            tick(6);
            check("zero_done_cnt", done_cnt, 1);
            check("zero_done_cyc", done_cyc, t0 + 1);
            check("zero_busy", busy_cnt, 1);
            check("zero_cs", frames, 0);
            check("zero_cclk", cclk_hi, 0);
        end

        clear_mon();
        sel = 1'b0; addr = 24'h000100; len = 8'd1; start = 1'b1;
        for (int i = 0; i < 2000 && done_cnt == 0; i++) tick(1);
        check("busy_start_frames", frames, 1);
        d1 = done_cyc;
        for (int i = 0; i < 2000 && frames < 2; i++) tick(1);
        start = 1'b0;
        check("busy_start_refall", frames == 2 && cs_fall_cyc - d1 >= 2, 1);
        for (int i = 0; i < 2000 && done_cnt < 2; i++) tick(1);
        tick(2);
        check("busy_start_done2", done_cnt, 2);
        check("busy_start_idle", busy, 0);

        launch(0, 24'($urandom), 1, t0);
        for (int i = 0; i < 500 && rises < 12; i++) tick(1);
        done_cnt = 0;
        rx_q.delete();
        sys_rstn = 1'b0;
        #1;
        check("midrst_cs_n", csn, 1);
        check("midrst_cclk", cclk, 0);
        check("midrst_busy", busy, 0);
        check("midrst_oe_n", {oe_n, mosi}, 2'b10);
        tick(3);
        sys_rstn = 1'b1;
        tick(100);
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_rdv", rx_q.size(), 0);
        fdata[0] = 8'hA5;
        launch(0, 24'h012345, 1, t0);
        wait_done();
        check_frame(1, 24'h012345, 1, t0);

        repeat (6) begin
            s = 1'($urandom_range(0, 1));
            l = $urandom_range(1, 4);
            a = 24'($urandom);
            for (int i = 0; i < 16; i++) fdata[i] = 8'($urandom);
            launch(s, a, l, t0);
            wait_done();
            check_frame(s ? 3 : 1, a, l, t0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
